// File: rtl/uart_fifo_ext.sv
`timescale 1ns/1ps
// uart_fifo_ext: buffered UART with independent TX and RX shift engines.
// Line format: DATA_BITS data bits, optional odd/even parity, 1 or 2 stop bits.
// Each RX FIFO entry holds {frame_err, parity_err, data[7:0]}.
//
// TX FSM
//   state     | meaning
//   TX_IDLE   | line high, waiting for the TX FIFO to become non-empty
//   TX_START  | driving the start bit (0)
//   TX_DATA   | driving data bits, LSB first
//   TX_PARITY | driving the parity bit (only when PARITY != 0)
//   TX_STOP   | driving STOP_BITS bit times of 1
//
// RX FSM
//   state        | meaning
//   RX_IDLE      | waiting for a synchronized 1->0 transition
//   RX_START_CHK | half a bit in, confirming the start bit is still low
//   RX_DATA      | sampling data bits at mid-bit
//   RX_PARITY    | sampling the parity bit (only when PARITY != 0)
//   RX_STOP      | sampling the first stop bit, then pushing the entry

// Small first-word fall-through FIFO, head visible straight from storage.
module uart_fifo_ext_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign level   = count;

  // Storage, pointers (wrap naturally at power-of-2 depth) and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module uart_fifo_ext #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8,
  localparam int LW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    data_in,
  input  logic          data_in_valid,
  output logic          data_in_ready,
  output logic [7:0]    data_out,
  output logic          data_out_frame_err,
  output logic          data_out_parity_err,
  output logic          data_out_valid,
  input  logic          data_out_ready,
  output logic          overrun,
  input  logic          err_clear,
  output logic [LW-1:0] tx_level,
  output logic [LW-1:0] rx_level,
  input  logic          serial_in,
  output logic          serial_out
);
  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int STOP_LEN     = STOP_BITS * CLKS_PER_BIT;
  localparam int TW           = $clog2(STOP_LEN + 1);

  localparam logic [TW-1:0] BIT_RELOAD  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_RELOAD = TW'(HALF_BIT - 1);
  localparam logic [TW-1:0] STOP_RELOAD = TW'(STOP_LEN - 1);
  localparam logic [7:0]    DATA_MASK   = 8'((16'd1 << DATA_BITS) - 16'd1);
  localparam logic [2:0]    LAST_BIT    = 3'(DATA_BITS - 1);
  localparam logic          PAR_ODD     = (PARITY == 1);
  localparam logic          PAR_EN      = (PARITY != 0);

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START_CHK, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_t;

  // ---------------- FIFOs ----------------
  logic [7:0] tx_head;
  logic       tx_full;
  logic       tx_empty;
  logic       tx_pop;

  logic [9:0] rx_head;
  logic [9:0] rx_entry;
  logic       rx_full;
  logic       rx_empty;
  logic       rx_push;

  uart_fifo_ext_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH), .LW(LW)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (data_in_valid),
    .push_data (data_in),
    .pop       (tx_pop),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .level     (tx_level)
  );

  uart_fifo_ext_fifo #(.WIDTH(10), .DEPTH(FIFO_DEPTH), .LW(LW)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_push),
    .push_data (rx_entry),
    .pop       (data_out_ready),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .level     (rx_level)
  );

  assign data_in_ready       = !tx_full;
  assign data_out_valid      = !rx_empty;
  assign data_out            = rx_head[7:0];
  assign data_out_parity_err = rx_head[8];
  assign data_out_frame_err  = rx_head[9];

  // ---------------- TX engine ----------------
  tx_state_t     tx_state;
  tx_state_t     tx_state_nxt;
  logic [TW-1:0] tx_timer;
  logic [TW-1:0] tx_reload;
  logic          tx_tc;
  logic [7:0]    tx_shift;
  logic [2:0]    tx_bit_cnt;
  logic          tx_par;
  logic          tx_line;

  assign tx_tc = (tx_timer == '0);

  // TX state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tx_state <= TX_IDLE;
    else        tx_state <= tx_state_nxt;
  end

  // TX next state; a frame ending with data queued goes straight to START.
  always_comb begin
    tx_state_nxt = tx_state;
    case (tx_state)
      TX_IDLE:   if (!tx_empty) tx_state_nxt = TX_START;
      TX_START:  if (tx_tc) tx_state_nxt = TX_DATA;
      TX_DATA:   if (tx_tc && tx_bit_cnt == LAST_BIT)
                   tx_state_nxt = PAR_EN ? TX_PARITY : TX_STOP;
      TX_PARITY: if (tx_tc) tx_state_nxt = TX_STOP;
      TX_STOP:   if (tx_tc) tx_state_nxt = tx_empty ? TX_IDLE : TX_START;
      default:   tx_state_nxt = TX_IDLE;
    endcase
  end

  // TX outputs: FIFO pop, line level and bit-timer reload for the next state.
  always_comb begin
    tx_pop = ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_tc)) && !tx_empty;
    case (tx_state)
      TX_START:  tx_line = 1'b0;
      TX_DATA:   tx_line = tx_shift[0];
      TX_PARITY: tx_line = tx_par;
      default:   tx_line = 1'b1;
    endcase
    case (tx_state_nxt)
      TX_START, TX_DATA, TX_PARITY: tx_reload = BIT_RELOAD;
      TX_STOP:                      tx_reload = STOP_RELOAD;
      default:                      tx_reload = '0;
    endcase
  end

  // TX datapath: down-counting bit timer, shift register, parity, line flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_timer   <= '0;
      tx_shift   <= '0;
      tx_bit_cnt <= '0;
      tx_par     <= 1'b0;
      serial_out <= 1'b1;
    end else begin
      tx_timer   <= tx_tc ? tx_reload : tx_timer - TW'(1);
      serial_out <= tx_line;
      if (tx_pop) begin
        tx_shift   <= tx_head & DATA_MASK;
        tx_bit_cnt <= '0;
        tx_par     <= (^(tx_head & DATA_MASK)) ^ PAR_ODD;
      end else if (tx_state == TX_DATA && tx_tc) begin
        tx_shift   <= tx_shift >> 1;
        tx_bit_cnt <= tx_bit_cnt + 3'd1;
      end
    end
  end

  // ---------------- RX engine ----------------
  rx_state_t     rx_state;
  rx_state_t     rx_state_nxt;
  logic [TW-1:0] rx_timer;
  logic [TW-1:0] rx_reload;
  logic          rx_tc;
  logic          rx_sync1;
  logic          rx_sync2;
  logic          rx_prev;
  logic          rx_fall;
  logic [7:0]    rx_shift;
  logic [7:0]    rx_shift_nxt;
  logic [2:0]    rx_bit_cnt;
  logic          rx_par_err;

  assign rx_tc    = (rx_timer == '0);
  assign rx_fall  = rx_prev && !rx_sync2;
  assign rx_entry = {~rx_sync2, rx_par_err, rx_shift};

  // Two-flop synchronizer plus one delayed copy for edge detection; idles high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_sync1 <= 1'b1;
      rx_sync2 <= 1'b1;
      rx_prev  <= 1'b1;
    end else begin
      rx_sync1 <= serial_in;
      rx_sync2 <= rx_sync1;
      rx_prev  <= rx_sync2;
    end
  end

  // RX state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rx_state <= RX_IDLE;
    else        rx_state <= rx_state_nxt;
  end

  // RX next state; a high sample at half-bit is a glitch, not a start bit.
  always_comb begin
    rx_state_nxt = rx_state;
    case (rx_state)
      RX_IDLE:      if (rx_fall) rx_state_nxt = RX_START_CHK;
      RX_START_CHK: if (rx_tc) rx_state_nxt = rx_sync2 ? RX_IDLE : RX_DATA;
      RX_DATA:      if (rx_tc && rx_bit_cnt == LAST_BIT)
                      rx_state_nxt = PAR_EN ? RX_PARITY : RX_STOP;
      RX_PARITY:    if (rx_tc) rx_state_nxt = RX_STOP;
      RX_STOP:      if (rx_tc) rx_state_nxt = RX_IDLE;
      default:      rx_state_nxt = RX_IDLE;
    endcase
  end

  // RX outputs: push at the stop sample, timer reload, next shift value.
  always_comb begin
    rx_push = (rx_state == RX_STOP) && rx_tc;
    case (rx_state_nxt)
      RX_START_CHK:                rx_reload = HALF_RELOAD;
      RX_DATA, RX_PARITY, RX_STOP: rx_reload = BIT_RELOAD;
      default:                     rx_reload = '0;
    endcase
    rx_shift_nxt = {1'b0, rx_shift[7:1]};
    rx_shift_nxt[DATA_BITS-1] = rx_sync2;
  end

  // RX datapath: bit timer, data assembly and parity check.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_timer   <= '0;
      rx_shift   <= '0;
      rx_bit_cnt <= '0;
      rx_par_err <= 1'b0;
    end else begin
      rx_timer <= rx_tc ? rx_reload : rx_timer - TW'(1);
      if (rx_state == RX_START_CHK) begin
        rx_shift   <= '0;
        rx_bit_cnt <= '0;
        rx_par_err <= 1'b0;
      end else if (rx_state == RX_DATA && rx_tc) begin
        rx_shift   <= rx_shift_nxt;
        rx_bit_cnt <= rx_bit_cnt + 3'd1;
      end else if (rx_state == RX_PARITY && rx_tc) begin
        rx_par_err <= rx_sync2 ^ (^rx_shift) ^ PAR_ODD;
      end
    end
  end

  // Sticky overrun; a drop in the same cycle as err_clear wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  overrun <= 1'b0;
    else if (rx_push && rx_full) overrun <= 1'b1;
    else if (err_clear)          overrun <= 1'b0;
  end
endmodule

// File: tb/tb_uart_fifo_ext.sv
`timescale 1ns/1ps
// Directed bench: dut_a is 8N1 driven directly on serial_in, dut_b is 7E2 in loopback.
module tb_uart_fifo_ext;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [7:0] a_data_in = '0;
  logic       a_din_valid = 1'b0;
  logic       a_din_ready;
  logic [7:0] a_dout;
  logic       a_ferr, a_perr, a_dout_valid;
  logic       a_dout_ready = 1'b0;
  logic       a_overrun;
  logic       a_err_clear = 1'b0;
  logic [3:0] a_tx_level, a_rx_level;
  logic       a_sin = 1'b1;
  logic       a_sout;

  logic [7:0] b_data_in = '0;
  logic       b_din_valid = 1'b0;
  logic       b_din_ready;
  logic [7:0] b_dout;
  logic       b_ferr, b_perr, b_dout_valid;
  logic       b_dout_ready = 1'b0;
  logic       b_overrun;
  logic       b_err_clear = 1'b0;
  logic [3:0] b_tx_level, b_rx_level;
  logic       b_sout;

  uart_fifo_ext #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000)) dut_a (
    .clk(clk), .reset(reset),
    .data_in(a_data_in), .data_in_valid(a_din_valid), .data_in_ready(a_din_ready),
    .data_out(a_dout), .data_out_frame_err(a_ferr), .data_out_parity_err(a_perr),
    .data_out_valid(a_dout_valid), .data_out_ready(a_dout_ready),
    .overrun(a_overrun), .err_clear(a_err_clear),
    .tx_level(a_tx_level), .rx_level(a_rx_level),
    .serial_in(a_sin), .serial_out(a_sout)
  );

  uart_fifo_ext #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000),
                  .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_b (
    .clk(clk), .reset(reset),
    .data_in(b_data_in), .data_in_valid(b_din_valid), .data_in_ready(b_din_ready),
    .data_out(b_dout), .data_out_frame_err(b_ferr), .data_out_parity_err(b_perr),
    .data_out_valid(b_dout_valid), .data_out_ready(b_dout_ready),
    .overrun(b_overrun), .err_clear(b_err_clear),
    .tx_level(b_tx_level), .rx_level(b_rx_level),
    .serial_in(b_sout), .serial_out(b_sout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 8N1 frame: idx 0 start, 1..8 data LSB first, 9 stop, beyond idle.
  function automatic logic frame_a(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return 1'b1;
  endfunction

  // 7E2 frame: idx 0 start, 1..7 data, 8 even parity, 9..10 stop, beyond idle.
  function automatic logic frame_b(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 7) return b[idx-1];
    if (idx == 8) return ^b[6:0];
    return 1'b1;
  endfunction

  // Called at the negedge right after the accept edge t of a lone byte.
  task automatic expect_a_frame(input logic [7:0] b, input string tag);
    @(negedge clk);
    check({tag, "_lvl_t1"}, a_tx_level, 0);
    check({tag, "_line_t1"}, a_sout, 1);
    for (int i = 0; i < 110; i++) begin
      @(negedge clk);
      check($sformatf("%s_line_%0d", tag, i), a_sout, frame_a(b, i / 10));
    end
  endtask

  // Drives one 8-bit frame on dut_a's serial_in; 100 cycles long.
  task automatic send_a(input logic [7:0] b, input logic stop);
    a_sin = 1'b0;
    repeat (10) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      a_sin = b[k];
      repeat (10) @(negedge clk);
    end
    a_sin = stop;
    repeat (10) @(negedge clk);
    a_sin = 1'b1;
  endtask

  task automatic pop_a();
    a_dout_ready = 1'b1;
    @(negedge clk);
    a_dout_ready = 1'b0;
  endtask

  task automatic pop_b();
    b_dout_ready = 1'b1;
    @(negedge clk);
    b_dout_ready = 1'b0;
  endtask

  logic [7:0] burst [9] = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h55, 8'hAA, 8'h3C, 8'hC3, 8'h7E};
  logic [7:0] rxb   [9] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_sout", a_sout, 1);
    check("rst_din_ready", a_din_ready, 1);
    check("rst_dout_valid", a_dout_valid, 0);
    check("rst_dout", a_dout, 0);
    check("rst_ferr", a_ferr, 0);
    check("rst_perr", a_perr, 0);
    check("rst_overrun", a_overrun, 0);
    check("rst_tx_level", a_tx_level, 0);
    check("rst_rx_level", a_rx_level, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte 0xA5 on the line.
    a_data_in = 8'hA5;
    a_din_valid = 1'b1;
    @(negedge clk);
    a_din_valid = 1'b0;
    check("a5_lvl_t", a_tx_level, 1);
    expect_a_frame(8'hA5, "a5");

    // Nine back-to-back bytes, FIFO fills, frames contiguous.
    a_data_in = burst[0];
    a_din_valid = 1'b1;
    @(negedge clk);
    fork
      begin
        for (int k = 1; k < 9; k++) begin
          check($sformatf("burst_rdy_%0d", k), a_din_ready, 1);
          a_data_in = burst[k];
          @(negedge clk);
        end
        a_din_valid = 1'b0;
        check("burst_full_lvl", a_tx_level, 8);
        check("burst_full_rdy", a_din_ready, 0);
      end
      begin
        @(negedge clk);
        check("burst_line_t1", a_sout, 1);
        for (int i = 0; i < 910; i++) begin
          @(negedge clk);
          check($sformatf("burst_line_%0d", i), a_sout,
                (i < 900) ? frame_a(burst[i / 100], (i % 100) / 10) : 1'b1);
        end
      end
    join
    check("burst_drained", a_tx_level, 0);

    // Loopback 7E2: 0x7F then 0x95 (bit 7 dropped -> 0x15), two stop bits.
    check("lb_rdy", b_din_ready, 1);
    b_data_in = 8'h7F;
    b_din_valid = 1'b1;
    @(negedge clk);
    b_data_in = 8'h95;
    @(negedge clk);
    b_din_valid = 1'b0;
    check("lb_tx_lvl", b_tx_level, 1);
    for (int i = 0; i < 240; i++) begin
      @(negedge clk);
      check($sformatf("lb_line_%0d", i), b_sout,
            (i < 110) ? frame_b(8'h7F, i / 10) :
            (i < 220) ? frame_b(8'h95, (i - 110) / 10) : 1'b1);
    end
    check("lb_rx_lvl", b_rx_level, 2);
    check("lb_valid", b_dout_valid, 1);
    check("lb_dout0", b_dout, 8'h7F);
    check("lb_ferr0", b_ferr, 0);
    check("lb_perr0", b_perr, 0);
    repeat (5) @(negedge clk);
    check("lb_rx_lvl_hold", b_rx_level, 2);
    pop_b();
    check("lb_dout1", b_dout, 8'h15);
    check("lb_ferr1", b_ferr, 0);
    check("lb_perr1", b_perr, 0);
    pop_b();
    check("lb_empty", b_dout_valid, 0);
    check("lb_overrun", b_overrun, 0);

    // Framing error frame, then a glitch, then a clean frame.
    send_a(8'h3C, 1'b0);
    repeat (3) @(negedge clk);
    check("ferr_valid", a_dout_valid, 1);
    check("ferr_dout", a_dout, 8'h3C);
    check("ferr_flag", a_ferr, 1);
    check("ferr_perr", a_perr, 0);
    pop_a();
    check("ferr_popped", a_rx_level, 0);
    a_sin = 1'b0;
    repeat (3) @(negedge clk);
    a_sin = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_lvl", a_rx_level, 0);
    check("glitch_valid", a_dout_valid, 0);
    send_a(8'h5A, 1'b1);
    repeat (2) @(negedge clk);
    check("clean_dout", a_dout, 8'h5A);
    check("clean_ferr", a_ferr, 0);
    check("clean_lvl", a_rx_level, 1);
    pop_a();

    // Overrun: fill the RX FIFO, drop one, clear, drop again while clearing.
    for (int k = 0; k < 8; k++) send_a(rxb[k], 1'b1);
    check("ovr_lvl8", a_rx_level, 8);
    check("ovr_before", a_overrun, 0);
    send_a(rxb[8], 1'b1);
    check("ovr_set", a_overrun, 1);
    check("ovr_lvl_still8", a_rx_level, 8);
    check("ovr_head", a_dout, rxb[0]);
    a_err_clear = 1'b1;
    @(negedge clk);
    a_err_clear = 1'b0;
    check("ovr_cleared", a_overrun, 0);
    check("ovr_clear_lvl", a_rx_level, 8);
    fork
      send_a(8'hAA, 1'b1);
      begin
        repeat (97) @(negedge clk);
        a_err_clear = 1'b1;
        @(negedge clk);
        a_err_clear = 1'b0;
      end
    join
    check("ovr_coincide", a_overrun, 1);
    a_err_clear = 1'b1;
    @(negedge clk);
    a_err_clear = 1'b0;
    check("ovr_cleared2", a_overrun, 0);
    a_dout_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("ovr_pop_%0d", k), a_dout, rxb[k]);
      check($sformatf("ovr_pop_ferr_%0d", k), a_ferr, 0);
      @(negedge clk);
    end
    a_dout_ready = 1'b0;
    check("ovr_empty", a_dout_valid, 0);
    check("ovr_empty_lvl", a_rx_level, 0);

    // Reset in the middle of a TX start bit and an RX frame.
    send_a(8'h42, 1'b1);
    a_sin = 1'b0;
    repeat (30) @(negedge clk);
    a_data_in = 8'h81;
    a_din_valid = 1'b1;
    @(negedge clk);
    a_data_in = 8'h18;
    @(negedge clk);
    a_data_in = 8'hE7;
    @(negedge clk);
    a_din_valid = 1'b0;
    check("mid_sout_low", a_sout, 0);
    check("mid_tx_lvl", a_tx_level, 2);
    check("mid_rx_lvl", a_rx_level, 1);
    check("mid_dout", a_dout, 8'h42);
    reset = 1'b0;
    #1;
    check("mrst_sout", a_sout, 1);
    check("mrst_tx_lvl", a_tx_level, 0);
    check("mrst_rx_lvl", a_rx_level, 0);
    check("mrst_valid", a_dout_valid, 0);
    check("mrst_dout", a_dout, 0);
    check("mrst_rdy", a_din_ready, 1);
    @(negedge clk);
    check("mrst_sout2", a_sout, 1);
    a_sin = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("post_sout", a_sout, 1);
    check("post_rx_lvl", a_rx_level, 0);
    a_data_in = 8'h3C;
    a_din_valid = 1'b1;
    @(negedge clk);
    a_din_valid = 1'b0;
    check("post_lvl_t", a_tx_level, 1);
    expect_a_frame(8'h3C, "post");
    check("post_rx_quiet", a_dout_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
